td4_core: RTL and testbench

- 4-bit single-cycle CPU core consuming the 16x8 program ROM; one instruction per enabled clock.
- Drives the ROM address from PC and decodes the returned byte combinationally: opcode [7:4], immediate [3:0].
- Holds registers A, B, PC, carry flag C and the registered output port; samples the 4-bit input port.
- Sits between the ROM and the board I/O (switches in, LEDs out).

---
 rtl/td4_pkg.sv | 34 +++
 rtl/td4_decode.sv | 35 +++
 rtl/td4_core.sv | 86 ++++++++
 tb/tb_td4_core.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared widths, opcode encodings and decode selector types for the TD4 core.
package td4_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_sel_t;

  typedef enum logic [1:0] {
    DST_A    = 2'd0,
    DST_B    = 2'd1,
    DST_OUT  = 2'd2,
    DST_NONE = 2'd3
  } dst_sel_t;

endpackage

// File: rtl/td4_decode.sv
// Combinational opcode decode: ALU source, write destination and jump kind.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] i_opcode,
  output src_sel_t   o_src_sel,
  output dst_sel_t   o_dst_sel,
  output logic       o_jump,
  output logic       o_jnc
);

  // Jumps, OUT im and NOPs use a zero source so the ALU carry-out clears C.
  always_comb begin
    o_src_sel = SRC_ZERO;
    o_dst_sel = DST_NONE;
    o_jump    = 1'b0;
    o_jnc     = 1'b0;
    case (i_opcode)
      OP_ADD_A:  begin o_src_sel = SRC_A;    o_dst_sel = DST_A;   end
      OP_MOV_AB: begin o_src_sel = SRC_B;    o_dst_sel = DST_A;   end
      OP_IN_A:   begin o_src_sel = SRC_IN;   o_dst_sel = DST_A;   end
      OP_MOV_AI: begin o_src_sel = SRC_ZERO; o_dst_sel = DST_A;   end
      OP_MOV_BA: begin o_src_sel = SRC_A;    o_dst_sel = DST_B;   end
      OP_ADD_B:  begin o_src_sel = SRC_B;    o_dst_sel = DST_B;   end
      OP_IN_B:   begin o_src_sel = SRC_IN;   o_dst_sel = DST_B;   end
      OP_MOV_BI: begin o_src_sel = SRC_ZERO; o_dst_sel = DST_B;   end
      OP_OUT_B:  begin o_src_sel = SRC_B;    o_dst_sel = DST_OUT; end
      OP_OUT_I:  begin o_src_sel = SRC_ZERO; o_dst_sel = DST_OUT; end
      OP_JNC:    o_jnc  = 1'b1;
      OP_JMP:    o_jump = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4_core.sv
// TD4 4-bit single-cycle CPU: fetches from an external 16x8 ROM, executes one
// instruction per enabled clock edge.
module td4_core
  import td4_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 4'h0,
  parameter logic [DATA_W-1:0] OUT_RESET = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              carry,
  output logic [DATA_W-1:0] a_dbg,
  output logic [DATA_W-1:0] b_dbg,
  output logic [ADDR_W-1:0] pc_dbg
);

  logic [DATA_W-1:0] r_a, r_b, r_out;
  logic [ADDR_W-1:0] r_pc;
  logic              r_c;

  logic [3:0]        w_opcode;
  logic [3:0]        w_imm;
  src_sel_t          w_src_sel;
  dst_sel_t          w_dst_sel;
  logic              w_jump, w_jnc;
  logic [DATA_W-1:0] w_src;
  logic [DATA_W:0]   w_sum;
  logic              w_take;

  assign w_opcode = rom_data[7:4];
  assign w_imm    = rom_data[3:0];

  td4_decode u_decode (
    .i_opcode  (w_opcode),
    .o_src_sel (w_src_sel),
    .o_dst_sel (w_dst_sel),
    .o_jump    (w_jump),
    .o_jnc     (w_jnc)
  );

  always_comb begin
    w_src = '0;
    case (w_src_sel)
      SRC_A:    w_src = r_a;
      SRC_B:    w_src = r_b;
      SRC_IN:   w_src = in_port;
      default:  w_src = '0;
    endcase
  end

  assign w_sum  = {1'b0, w_src} + {1'b0, w_imm};
  // JNC looks at the flag held before this edge, not the one being written.
  assign w_take = w_jump | (w_jnc & ~r_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= 1'b0;
      r_pc  <= RESET_PC;
      r_out <= OUT_RESET;
    end else if (en) begin
      r_c  <= w_sum[DATA_W];
      r_pc <= w_take ? w_imm : r_pc + 4'd1;
      case (w_dst_sel)
        DST_A:   r_a   <= w_sum[DATA_W-1:0];
        DST_B:   r_b   <= w_sum[DATA_W-1:0];
        DST_OUT: r_out <= w_sum[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  assign rom_addr = r_pc;
  assign pc_dbg   = r_pc;
  assign a_dbg    = r_a;
  assign b_dbg    = r_b;
  assign carry    = r_c;
  assign out_port = r_out;

endmodule

// File: tb/tb_td4_core.sv
// Directed-program bench for td4_core; ROM is modelled as a combinational array.
module tb_td4_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic       carry;
  logic [3:0] a_dbg, b_dbg, pc_dbg;

  logic [7:0] rom [16];
  int n_checks = 0;
  int n_errors = 0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  td4_core #(.RESET_PC(4'h0), .OUT_RESET(4'h0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .in_port  (in_port),
    .out_port (out_port),
    .carry    (carry),
    .a_dbg    (a_dbg),
    .b_dbg    (b_dbg),
    .pc_dbg   (pc_dbg)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) rom[i] = fill;
  endtask

  // Hold reset across a clock edge, then release with en high.
  task automatic restart;
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    in_port = 4'hE;
    clear_rom(8'h00);
    #1;
    chk("por_pc", {4'h0, pc_dbg}, 8'h00);
    chk("por_out", {4'h0, out_port}, 8'h00);

    // Main demo program
    clear_rom(8'h00);
    rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'h3D; rom[3] = 8'h01; rom[4] = 8'hE3;
    rom[5] = 8'h51; rom[6] = 8'hE1; rom[7] = 8'hB0; rom[8] = 8'hBF; rom[9] = 8'hF7;
    restart();
    step(2);
    chk("main_e2_out", {4'h0, out_port}, 8'h0E);
    step(8);
    @(negedge clk);
    en = 1'b0;
    step(5);
    chk("hold_a", {4'h0, a_dbg}, 8'h00);
    chk("hold_b", {4'h0, b_dbg}, 8'h0F);
    chk("hold_c", {7'h0, carry}, 8'h00);
    chk("hold_pc", {4'h0, pc_dbg}, 8'h06);
    chk("hold_addr", {4'h0, rom_addr}, 8'h06);
    chk("hold_out", {4'h0, out_port}, 8'h0E);
    @(negedge clk);
    en = 1'b1;
    step(1);
    chk("main_e11_pc", {4'h0, pc_dbg}, 8'h01);
    chk("main_e11_b", {4'h0, b_dbg}, 8'h0F);
    step(1);
    chk("main_e12_out", {4'h0, out_port}, 8'h0F);
    step(8);
    chk("main_e20_b", {4'h0, b_dbg}, 8'h00);
    chk("main_e20_c", {7'h0, carry}, 8'h01);
    step(1);
    chk("main_e21_pc", {4'h0, pc_dbg}, 8'h07);
    chk("main_e21_c", {7'h0, carry}, 8'h00);
    step(1);
    chk("main_e22_out", {4'h0, out_port}, 8'h00);
    step(1);
    chk("main_e23_out", {4'h0, out_port}, 8'h0F);
    step(1);
    chk("main_e24_out", {4'h0, out_port}, 8'h0F);
    chk("main_e24_pc", {4'h0, pc_dbg}, 8'h07);
    step(1);
    chk("main_e25_out", {4'h0, out_port}, 8'h00);

    // Remaining move/IN/OUT forms, then asynchronous reset mid-run
    clear_rom(8'h00);
    rom[0] = 8'h75; rom[1] = 8'h13; rom[2] = 8'h2F; rom[3] = 8'h42; rom[4] = 8'h99;
    restart();
    step(2);
    chk("movab_a", {4'h0, a_dbg}, 8'h08);
    step(1);
    chk("ina_a", {4'h0, a_dbg}, 8'h0D);
    chk("ina_c", {7'h0, carry}, 8'h01);
    step(1);
    chk("movba_b", {4'h0, b_dbg}, 8'h0F);
    chk("movba_c", {7'h0, carry}, 8'h00);
    step(1);
    chk("outb_out", {4'h0, out_port}, 8'h08);
    chk("outb_c", {7'h0, carry}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a", {4'h0, a_dbg}, 8'h00);
    chk("arst_b", {4'h0, b_dbg}, 8'h00);
    chk("arst_c", {7'h0, carry}, 8'h00);
    chk("arst_out", {4'h0, out_port}, 8'h00);
    chk("arst_addr", {4'h0, rom_addr}, 8'h00);

    // Carry wrap and clear
    clear_rom(8'h00);
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'h73;
    restart();
    step(2);
    chk("wrap_a", {4'h0, a_dbg}, 8'h00);
    chk("wrap_c", {7'h0, carry}, 8'h01);
    step(1);
    chk("wrap_clr_b", {4'h0, b_dbg}, 8'h03);
    chk("wrap_clr_c", {7'h0, carry}, 8'h00);

    // JNC not taken with C=1, then taken with C=0
    clear_rom(8'h00);
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'h3F; rom[3] = 8'h01;
    rom[4] = 8'hE9; rom[5] = 8'h80; rom[6] = 8'hEA;
    restart();
    step(4);
    chk("jnc_pre_c", {7'h0, carry}, 8'h01);
    step(1);
    chk("jnc_nt_pc", {4'h0, pc_dbg}, 8'h05);
    chk("jnc_nt_c", {7'h0, carry}, 8'h00);
    step(2);
    chk("jnc_tk_pc", {4'h0, pc_dbg}, 8'h0A);

    // PC wrap through NOPs
    clear_rom(8'h80);
    rom[0] = 8'h77; rom[1] = 8'h3A; rom[2] = 8'hBC;
    restart();
    step(15);
    chk("pcwrap_e15", {4'h0, pc_dbg}, 8'h0F);
    step(1);
    chk("pcwrap_pc", {4'h0, pc_dbg}, 8'h00);
    chk("nop_a", {4'h0, a_dbg}, 8'h0A);
    chk("nop_b", {4'h0, b_dbg}, 8'h07);
    chk("nop_out", {4'h0, out_port}, 8'h0C);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
